// File: rtl/iir_tdm_sched.sv
// Time-shared biquad engine: one multiplier/accumulator walks five taps per
// accepted sample over per-channel histories, then saturates and writes back.
module iir_tdm_sched #(
  parameter int unsigned NCH  = 4,
  parameter int unsigned CHW  = 2,
  parameter int unsigned DW   = 12,
  parameter int unsigned CW   = 8,
  parameter int unsigned FRAC = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [CHW-1:0]       in_ch,
  input  logic signed [DW-1:0] din,
  input  logic                 coef_we,
  input  logic [2:0]           coef_addr,
  input  logic signed [CW-1:0] coef_wdata,
  input  logic                 hist_clr,
  output logic                 out_valid,
  output logic [CHW-1:0]       out_ch,
  output logic signed [DW-1:0] dout,
  output logic                 busy
);

  localparam int unsigned AW = 32;
  localparam int unsigned PW = CW + DW;
  localparam logic [2:0]  LAST_TAP = 3'd4;

  localparam logic signed [AW-1:0] SAT_MAX = AW'((2 ** (DW - 1)) - 1);
  localparam logic signed [AW-1:0] SAT_MIN = AW'(-(2 ** (DW - 1)));

  localparam logic signed [CW-1:0] B0_RST = CW'(5);
  localparam logic signed [CW-1:0] B1_RST = CW'(9);
  localparam logic signed [CW-1:0] B2_RST = CW'(5);
  localparam logic signed [CW-1:0] A1_RST = CW'(-71);
  localparam logic signed [CW-1:0] A2_RST = CW'(25);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_WB   = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [2:0]            tap_q, tap_d;
  logic signed [AW-1:0]  acc_q, acc_d;
  logic [CHW-1:0]        ch_q, ch_d;
  logic signed [DW-1:0]  x_q, x_d;

  logic signed [DW-1:0]  x1_q [NCH];
  logic signed [DW-1:0]  x1_d [NCH];
  logic signed [DW-1:0]  x2_q [NCH];
  logic signed [DW-1:0]  x2_d [NCH];
  logic signed [DW-1:0]  y1_q [NCH];
  logic signed [DW-1:0]  y1_d [NCH];
  logic signed [DW-1:0]  y2_q [NCH];
  logic signed [DW-1:0]  y2_d [NCH];

  logic signed [CW-1:0]  b0_q, b0_d, b1_q, b1_d, b2_q, b2_d;
  logic signed [CW-1:0]  a1_q, a1_d, a2_q, a2_d;

  logic                  in_ready_q, in_ready_d;
  logic                  busy_q, busy_d;
  logic                  out_valid_q, out_valid_d;
  logic [CHW-1:0]        out_ch_q, out_ch_d;
  logic signed [DW-1:0]  dout_q, dout_d;

  logic signed [CW-1:0]  coef_sel_c;
  logic signed [DW-1:0]  samp_sel_c;
  logic                  fb_tap_c;
  logic signed [PW-1:0]  prod_c;
  logic signed [AW-1:0]  shifted_c;
  logic signed [DW-1:0]  y_sat_c;

  assign in_ready  = in_ready_q;
  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign out_ch    = out_ch_q;
  assign dout      = dout_q;

  // Tap operand mux for the shared multiplier; taps 3 and 4 are the feedback terms
  always_comb begin
    coef_sel_c = '0;
    samp_sel_c = '0;
    fb_tap_c   = 1'b0;
    case (tap_q)
      3'd0: begin
        coef_sel_c = b0_q;
        samp_sel_c = x_q;
      end
      3'd1: begin
        coef_sel_c = b1_q;
        samp_sel_c = x1_q[ch_q];
      end
      3'd2: begin
        coef_sel_c = b2_q;
        samp_sel_c = x2_q[ch_q];
      end
      3'd3: begin
        coef_sel_c = a1_q;
        samp_sel_c = y1_q[ch_q];
        fb_tap_c   = 1'b1;
      end
      3'd4: begin
        coef_sel_c = a2_q;
        samp_sel_c = y2_q[ch_q];
        fb_tap_c   = 1'b1;
      end
      default: ;
    endcase
  end

  assign prod_c    = PW'(coef_sel_c) * PW'(samp_sel_c);
  assign shifted_c = acc_q >>> FRAC;

  always_comb begin
    if (shifted_c > SAT_MAX) begin
      y_sat_c = DW'(SAT_MAX);
    end else if (shifted_c < SAT_MIN) begin
      y_sat_c = DW'(SAT_MIN);
    end else begin
      y_sat_c = DW'(shifted_c);
    end
  end

  // Next-state and datapath control
  always_comb begin
    state_d     = state_q;
    tap_d       = tap_q;
    acc_d       = acc_q;
    ch_d        = ch_q;
    x_d         = x_q;
    x1_d        = x1_q;
    x2_d        = x2_q;
    y1_d        = y1_q;
    y2_d        = y2_q;
    b0_d        = b0_q;
    b1_d        = b1_q;
    b2_d        = b2_q;
    a1_d        = a1_q;
    a2_d        = a2_q;
    out_valid_d = 1'b0;
    out_ch_d    = out_ch_q;
    dout_d      = dout_q;

    case (state_q)
      S_IDLE: begin
        if (coef_we) begin
          case (coef_addr)
            3'd0:    b0_d = coef_wdata;
            3'd1:    b1_d = coef_wdata;
            3'd2:    b2_d = coef_wdata;
            3'd3:    a1_d = coef_wdata;
            3'd4:    a2_d = coef_wdata;
            default: ;
          endcase
        end
        if (hist_clr) begin
          for (int i = 0; i < int'(NCH); i++) begin
            x1_d[i] = '0;
            x2_d[i] = '0;
            y1_d[i] = '0;
            y2_d[i] = '0;
          end
        end
        if (in_valid) begin
          x_d     = din;
          ch_d    = in_ch;
          acc_d   = '0;
          tap_d   = '0;
          state_d = S_MAC;
        end
      end
      S_MAC: begin
        if (fb_tap_c) begin
          acc_d = acc_q - AW'(prod_c);
        end else begin
          acc_d = acc_q + AW'(prod_c);
        end
        tap_d = tap_q + 3'd1;
        if (tap_q == LAST_TAP) begin
          state_d = S_WB;
        end
      end
      S_WB: begin
        x2_d[ch_q]  = x1_q[ch_q];
        x1_d[ch_q]  = x_q;
        y2_d[ch_q]  = y1_q[ch_q];
        y1_d[ch_q]  = y_sat_c;
        dout_d      = y_sat_c;
        out_ch_d    = ch_q;
        out_valid_d = 1'b1;
        state_d     = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    in_ready_d = (state_d == S_IDLE);
    busy_d     = ~in_ready_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      tap_q       <= '0;
      acc_q       <= '0;
      ch_q        <= '0;
      x_q         <= '0;
      for (int i = 0; i < int'(NCH); i++) begin
        x1_q[i] <= '0;
        x2_q[i] <= '0;
        y1_q[i] <= '0;
        y2_q[i] <= '0;
      end
      b0_q        <= B0_RST;
      b1_q        <= B1_RST;
      b2_q        <= B2_RST;
      a1_q        <= A1_RST;
      a2_q        <= A2_RST;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      dout_q      <= '0;
    end else begin
      state_q     <= state_d;
      tap_q       <= tap_d;
      acc_q       <= acc_d;
      ch_q        <= ch_d;
      x_q         <= x_d;
      x1_q        <= x1_d;
      x2_q        <= x2_d;
      y1_q        <= y1_d;
      y2_q        <= y2_d;
      b0_q        <= b0_d;
      b1_q        <= b1_d;
      b2_q        <= b2_d;
      a1_q        <= a1_d;
      a2_q        <= a2_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      out_ch_q    <= out_ch_d;
      dout_q      <= dout_d;
    end
  end

endmodule

// File: tb/tb_iir_tdm_sched.sv
// Bench for iir_tdm_sched: directed cases plus random traffic, all checked
// against a per-channel difference-equation model.
module tb_iir_tdm_sched;

  localparam int NCH  = 4;
  localparam int CHW  = 2;
  localparam int DW   = 12;
  localparam int CW   = 8;
  localparam int FRAC = 6;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 in_valid;
  logic                 in_ready;
  logic [CHW-1:0]       in_ch;
  logic signed [DW-1:0] din;
  logic                 coef_we;
  logic [2:0]           coef_addr;
  logic signed [CW-1:0] coef_wdata;
  logic                 hist_clr;
  logic                 out_valid;
  logic [CHW-1:0]       out_ch;
  logic signed [DW-1:0] dout;
  logic                 busy;

  int nvec = 0;
  int nerr = 0;

  // Reference state: coefficients b0,b1,b2,a1,a2 and per-channel history
  int mc [5];
  int mx1 [NCH];
  int mx2 [NCH];
  int my1 [NCH];
  int my2 [NCH];

  always #5 clk = ~clk;

  iir_tdm_sched #(
    .NCH(NCH), .CHW(CHW), .DW(DW), .CW(CW), .FRAC(FRAC)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_ch(in_ch), .din(din), .coef_we(coef_we), .coef_addr(coef_addr),
    .coef_wdata(coef_wdata), .hist_clr(hist_clr), .out_valid(out_valid),
    .out_ch(out_ch), .dout(dout), .busy(busy)
  );

  task automatic chk(input string tag, input int got, input int exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic void model_clear();
    for (int i = 0; i < NCH; i++) begin
      mx1[i] = 0; mx2[i] = 0; my1[i] = 0; my2[i] = 0;
    end
  endfunction

  function automatic void model_reset();
    mc[0] = 5; mc[1] = 9; mc[2] = 5; mc[3] = -71; mc[4] = 25;
    model_clear();
  endfunction

  function automatic int model_step(input int ch, input int x);
    int acc;
    int y;
    acc = mc[0]*x + mc[1]*mx1[ch] + mc[2]*mx2[ch] - mc[3]*my1[ch] - mc[4]*my2[ch];
    y = acc >>> FRAC;
    if (y > 2047) y = 2047;
    if (y < -2048) y = -2048;
    mx2[ch] = mx1[ch]; mx1[ch] = x;
    my2[ch] = my1[ch]; my1[ch] = y;
    return y;
  endfunction

  task automatic wr_coef(input int addr, input int val);
    @(negedge clk);
    coef_we = 1'b1; coef_addr = 3'(addr); coef_wdata = CW'(val);
    @(posedge clk); #1;
    coef_we = 1'b0;
    if (addr < 5) mc[addr] = val;
  endtask

  // One sample through the engine; clr rides with the handshake, mid_wr
  // attempts a b0=0 write during the first MAC cycle (must be ignored).
  task automatic apply(input int ch, input int d, input bit clr, input bit mid_wr,
                       output int got);
    int exp_y;
    int cyc;
    cyc = 0;
    @(negedge clk);
    while (!in_ready && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("ready_wait", int'(in_ready), 1);
    if (clr) model_clear();
    exp_y = model_step(ch, d);
    in_valid = 1'b1; in_ch = CHW'(ch); din = DW'(d); hist_clr = clr;
    @(posedge clk); #1;
    in_valid = 1'b0; hist_clr = 1'b0;
    if (mid_wr) begin
      coef_we = 1'b1; coef_addr = 3'd0; coef_wdata = '0;
    end
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      chk("ready_low_busy", int'(in_ready), 0);
      @(posedge clk); #1;
      coef_we = 1'b0;
      cyc++;
    end
    chk("latency", cyc, 6);
    chk("out_valid", int'(out_valid), 1);
    chk("dout", int'(dout), exp_y);
    chk("out_ch", int'(out_ch), ch);
    chk("ready_with_ov", int'(in_ready), 1);
    got = int'(dout);
    @(posedge clk); #1;
    chk("ov_one_cycle", int'(out_valid), 0);
  endtask

  initial begin
    int got;
    int minv;
    int seen;
    rst = 1'b1; in_valid = 1'b0; in_ch = '0; din = '0;
    coef_we = 1'b0; coef_addr = '0; coef_wdata = '0; hist_clr = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_dout", int'(dout), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_out_ch", int'(out_ch), 0);

    // Ch0 impulse with default coefficients
    apply(0, 64, 0, 0, got); chk("imp0_a", got, 5);
    apply(0, 0, 0, 0, got);  chk("imp0_b", got, 14);
    apply(0, 0, 0, 0, got);  chk("imp0_c", got, 18);

    // Ch1 impulse interleaved with ch0 zeros after a clean history
    apply(1, 64, 1, 0, got); chk("imp1_a", got, 5);
    apply(0, 0, 0, 0, got);  chk("zero0_a", got, 0);
    apply(1, 0, 0, 0, got);  chk("imp1_b", got, 14);
    apply(0, 0, 0, 0, got);  chk("zero0_b", got, 0);
    apply(1, 0, 0, 0, got);  chk("imp1_c", got, 18);
    apply(0, 0, 0, 0, got);  chk("zero0_c", got, 0);

    // Ch2 saturation in both directions
    minv = 0;
    for (int i = 0; i < 40; i++) begin
      apply(2, 2047, 0, 0, got);
      if (got < minv) minv = got;
    end
    chk("clamp_hi", got, 2047);
    chk("never_neg", minv, 0);
    for (int i = 0; i < 40; i++) apply(2, -2048, 0, 0, got);
    chk("clamp_lo", got, -2048);

    // Coefficient writes: ignored while busy, honoured in idle, bad address inert
    apply(3, 64, 1, 1, got); chk("mac_wr_ignored", got, 5);
    wr_coef(0, 64); wr_coef(1, 0); wr_coef(2, 0); wr_coef(3, 0); wr_coef(4, 0);
    apply(3, -100, 1, 0, got); chk("passthru", got, -100);
    wr_coef(6, 55);
    apply(3, -100, 0, 0, got); chk("addr6_inert", got, -100);

    // Reset in the middle of a ch0 sample
    @(negedge clk);
    in_valid = 1'b1; in_ch = '0; din = DW'(64);
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("rst_mid_no_ov", seen, 0);
    chk("rst_mid_ready", int'(in_ready), 1);
    chk("rst_mid_busy", int'(busy), 0);
    model_reset();
    apply(0, 64, 0, 0, got); chk("post_rst_imp", got, 5);

    // Standalone history clear in idle
    @(negedge clk);
    hist_clr = 1'b1;
    @(posedge clk); #1;
    hist_clr = 1'b0;
    model_clear();
    apply(0, 64, 0, 0, got); chk("hist_clr_imp", got, 5);

    // Random traffic with occasional coefficient writes and clears
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 7) == 0)
        wr_coef(int'($urandom_range(0, 7)), int'($urandom_range(0, 255)) - 128);
      apply(int'($urandom_range(0, NCH - 1)), int'($urandom_range(0, 4095)) - 2048,
            ($urandom_range(0, 15) == 0), 1'b0, got);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
